// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/subtract: carry chain split into SEGS registered segments.
// Optional macro ADDSUB_SAT_EN clamps the result to the signed extreme on overflow.
module addsub_pipe #(
    parameter int WIDTH = 21,
    parameter int SEGS  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / SEGS;

    // Subtract folds into an add: in2 + ~in1 + 1.
    logic [WIDTH-1:0] opb;
    logic             cin;
    assign opb = mode ? in1 : ~in1;
    assign cin = ~mode;

    // vld_in[k] is the valid bit presented to stage k; the last pipe bit is out_valid.
    logic [SEGS-1:0] vld_pipe_q, vld_pipe_d;
    logic [SEGS-1:0] vld_in;

    if (SEGS == 1) begin : g_vin_single
        assign vld_in = in_valid;
    end else begin : g_vin_multi
        assign vld_in = {vld_pipe_q[SEGS-2:0], in_valid};
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (en) vld_pipe_d = vld_in;
        else    vld_pipe_d[SEGS-1] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_pipe_q <= '0;
        else       vld_pipe_q <= vld_pipe_d;
    end

    // Intermediate stages: each keeps the finished low result segments and the
    // operand segments still waiting for their turn in the carry chain.
    for (genvar k = 0; k < SEGS - 1; k++) begin : g_stg
        localparam int LW  = (k + 1) * SW;
        localparam int HW  = WIDTH - LW;
        localparam int PHW = HW + SW;

        logic [SW:0]   seg_sum;
        logic [LW-1:0] res_q, res_d;
        logic [HW-1:0] a_q, a_d, b_q, b_d;
        logic          c_q, c_d, m_q, m_d, s2_q, s2_d, s1_q, s1_d;

        if (k == 0) begin : g_head
            assign seg_sum = {1'b0, in2[SW-1:0]} + {1'b0, opb[SW-1:0]} + {{SW{1'b0}}, cin};

            always_comb begin
                res_d = res_q;
                a_d   = a_q;
                b_d   = b_q;
                c_d   = c_q;
                m_d   = m_q;
                s2_d  = s2_q;
                s1_d  = s1_q;
                if (en) begin
                    res_d = seg_sum[SW-1:0];
                    a_d   = in2[WIDTH-1:SW];
                    b_d   = opb[WIDTH-1:SW];
                    c_d   = seg_sum[SW];
                    m_d   = mode;
                    s2_d  = in2[WIDTH-1];
                    s1_d  = in1[WIDTH-1];
                end
            end
        end else begin : g_body
            assign seg_sum = {1'b0, g_stg[k-1].a_q[SW-1:0]} + {1'b0, g_stg[k-1].b_q[SW-1:0]}
                           + {{SW{1'b0}}, g_stg[k-1].c_q};

            always_comb begin
                res_d = res_q;
                a_d   = a_q;
                b_d   = b_q;
                c_d   = c_q;
                m_d   = m_q;
                s2_d  = s2_q;
                s1_d  = s1_q;
                if (en) begin
                    res_d = {seg_sum[SW-1:0], g_stg[k-1].res_q};
                    a_d   = g_stg[k-1].a_q[PHW-1:SW];
                    b_d   = g_stg[k-1].b_q[PHW-1:SW];
                    c_d   = seg_sum[SW];
                    m_d   = g_stg[k-1].m_q;
                    s2_d  = g_stg[k-1].s2_q;
                    s1_d  = g_stg[k-1].s1_q;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                res_q <= '0;
                a_q   <= '0;
                b_q   <= '0;
                c_q   <= 1'b0;
                m_q   <= 1'b0;
                s2_q  <= 1'b0;
                s1_q  <= 1'b0;
            end else begin
                res_q <= res_d;
                a_q   <= a_d;
                b_q   <= b_d;
                c_q   <= c_d;
                m_q   <= m_d;
                s2_q  <= s2_d;
                s1_q  <= s1_d;
            end
        end
    end

    // Last segment: its sum goes straight into the output registers.
    logic [WIDTH-1:0] raw;
    logic             raw_c, fin_m, fin_s2, fin_s1;

    if (SEGS == 1) begin : g_fin_single
        logic [WIDTH:0] full;
        assign full   = {1'b0, in2} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        assign raw    = full[WIDTH-1:0];
        assign raw_c  = full[WIDTH];
        assign fin_m  = mode;
        assign fin_s2 = in2[WIDTH-1];
        assign fin_s1 = in1[WIDTH-1];
    end else begin : g_fin_tail
        logic [SW:0] top;
        assign top    = {1'b0, g_stg[SEGS-2].a_q} + {1'b0, g_stg[SEGS-2].b_q}
                      + {{SW{1'b0}}, g_stg[SEGS-2].c_q};
        assign raw    = {top[SW-1:0], g_stg[SEGS-2].res_q};
        assign raw_c  = top[SW];
        assign fin_m  = g_stg[SEGS-2].m_q;
        assign fin_s2 = g_stg[SEGS-2].s2_q;
        assign fin_s1 = g_stg[SEGS-2].s1_q;
    end

    logic raw_ovf;
    assign raw_ovf = fin_m ? ((fin_s2 == fin_s1) && (raw[WIDTH-1] != fin_s2))
                           : ((fin_s2 != fin_s1) && (raw[WIDTH-1] != fin_s2));

    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;

    always_comb begin
        out_d  = out_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (en && vld_in[SEGS-1]) begin
            cout_d = raw_c;
            ovf_d  = raw_ovf;
`ifdef ADDSUB_SAT_EN
            // A wrapped-negative sign means the true result overflowed upward.
            if (raw_ovf)
                out_d = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
            else
                out_d = raw;
`else
            out_d = raw;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = vld_pipe_q[SEGS-1];
    assign out       = out_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=21, SEGS=3) with directed, hand-computed vectors.
module tb_addsub_pipe;

    logic        clk, reset, en, in_valid, mode;
    logic [20:0] in1, in2, out;
    logic        out_valid, cout, ovf;

    addsub_pipe #(.WIDTH(21), .SEGS(3)) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .mode(mode),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out(out), .cout(cout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] res;
        logic        c;
        logic        o;
        int          acc_en;
        int          acc_raw;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   raw_edges = 0;
    int   en_edges = 0;
    logic last_en = 1'b0;

`ifdef ADDSUB_SAT_EN
    localparam logic [20:0] E5 = 21'h0FFFFF, E6 = 21'h100000, ST6 = 21'h100000, ST7 = 21'h0FFFFF;
`else
    localparam logic [20:0] E5 = 21'h1FFFFE, E6 = 21'h0FFFFF, ST6 = 21'h000000, ST7 = 21'h100010;
`endif

    // Mixed stream: mode, in2, in1, expected out/cout/ovf, latency in raw clock edges.
    logic        s_m   [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    logic [20:0] s_in2 [8] = '{21'h5, 21'h3, 21'h0FF000, 21'h1FFFFF, 21'h155555, 21'h012345, 21'h100000, 21'h000010};
    logic [20:0] s_in1 [8] = '{21'h3, 21'h5, 21'h000800, 21'h1FFFFF, 21'h0AAAAA, 21'h000345, 21'h100000, 21'h100000};
    logic [20:0] s_res [8] = '{21'h8, 21'h1FFFFE, 21'h0FF800, 21'h0, 21'h1FFFFF, 21'h012000, ST6, ST7};
    logic        s_c   [8] = '{0, 0, 0, 1, 0, 1, 1, 0};
    logic        s_o   [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int          s_lat [8] = '{3, 3, 5, 5, 3, 3, 3, 3};

    always @(posedge clk) begin
        raw_edges <= raw_edges + 1;
        if (en) en_edges <= en_edges + 1;
        last_en <= en;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic issue(input logic m, input logic [20:0] a2, input logic [20:0] a1,
                         input logic [20:0] r, input logic c, input logic o, input int lat);
        exp_t e;
        mode = m;
        in2 = a2;
        in1 = a1;
        in_valid = 1'b1;
        e.res = r;
        e.c = c;
        e.o = o;
        e.acc_en = en_edges;
        e.acc_raw = raw_edges;
        e.lat = lat;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            chk("valid_after_stall_edge", {31'd0, last_en}, 32'd1);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_out_valid: got out_valid=1 with out=%0h, expected no result", out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out", {11'd0, out}, {11'd0, mon_e.res});
                chk("cout", {31'd0, cout}, {31'd0, mon_e.c});
                chk("ovf", {31'd0, ovf}, {31'd0, mon_e.o});
                chk("latency_en_edges", en_edges - mon_e.acc_en, 3);
                chk("latency_cycles", raw_edges - mon_e.acc_raw, mon_e.lat);
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1;
        en = 1'b1;
        in_valid = 1'b0;
        mode = 1'b0;
        in1 = '0;
        in2 = '0;
        #2;
        chk("reset_out_valid", {31'd0, out_valid}, 0);
        chk("reset_out", {11'd0, out}, 0);
        chk("reset_cout", {31'd0, cout}, 0);
        chk("reset_ovf", {31'd0, ovf}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(0, 21'd100, 21'd30, 21'd70, 1, 0, 3);         idle(3);
        issue(0, 21'd0, 21'd1, 21'h1FFFFF, 0, 0, 3);        idle(3);
        issue(1, 21'h7F, 21'h01, 21'h80, 0, 0, 3);          idle(3);
        issue(1, 21'h3FFF, 21'h1, 21'h4000, 0, 0, 3);       idle(3);
        issue(1, 21'h1FFFFF, 21'h1, 21'h0, 1, 0, 3);        idle(3);
        issue(1, 21'h0FFFFF, 21'h0FFFFF, E5, 0, 1, 3);      idle(3);
        issue(0, 21'h100000, 21'h1, E6, 1, 1, 3);           idle(3);

        // Two stalled edges after token 3; the input offered during the stall must be dropped.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                en = 1'b0;
                in_valid = 1'b1;
                in2 = 21'h0ABCDE;
                in1 = 21'h012345;
                @(negedge clk);
                in_valid = 1'b0;
                @(negedge clk);
                en = 1'b1;
            end
            issue(s_m[i], s_in2[i], s_in1[i], s_res[i], s_c[i], s_o[i], s_lat[i]);
        end
        idle(5);

        // Asynchronous reset with tokens in flight: the oldest is already on the outputs.
        issue(0, 21'd9, 21'd4, 21'd5, 1, 0, 3);
        issue(1, 21'd7, 21'd8, 21'd15, 0, 0, 3);
        issue(1, 21'h1FFFF0, 21'h20, 21'h10, 1, 0, 3);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 0);
        chk("midreset_out", {11'd0, out}, 0);
        chk("midreset_cout", {31'd0, cout}, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postreset_no_valid", {31'd0, out_valid}, 0);
        end
        issue(0, 21'd50, 21'd20, 21'd30, 1, 0, 3);
        idle(1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
